// File: rtl/rtl_pkg.sv
// Shared types and constants for the two-requester arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise requester 0 wins ties.
package rtl_pkg;

  localparam int unsigned NUM_REQ_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  localparam logic [1:0] GRANT_RST = 2'b00;

endpackage

// File: rtl/rtl_prio_sel.sv
// Combinational winner selection for a free resource.
// ARB_ROUND_ROBIN_EN: ties go to the requester not granted most recently.
module rtl_prio_sel
  import rtl_pkg::*;
(
  input  logic [1:0] request,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       last_ptr,
`endif
  output logic [1:0] winner
);

  always_comb begin
    winner = 2'b00;
    if (request == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = last_ptr ? 2'b01 : 2'b10;
`else
      winner = 2'b01;
`endif
    end else begin
      winner = request;
    end
  end

endmodule

// File: rtl/rtl.sv
// Two-requester arbiter with non-preemptive ownership and a registered grant.
// ARB_ROUND_ROBIN_EN adds the last-granted pointer used for round-robin tie-break.
module rtl
  import rtl_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] request,
  output logic [NUM_REQ-1:0] grant
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] winner;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_ptr;
`endif

  rtl_prio_sel u_prio_sel (
    .request (request),
`ifdef ARB_ROUND_ROBIN_EN
    .last_ptr(last_ptr),
`endif
    .winner  (winner)
  );

  // An owner keeps the resource while it asks; on release it hands over directly.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (winner[0])      state_nxt = OWN0;
        else if (winner[1]) state_nxt = OWN1;
        else                state_nxt = IDLE;
      end
      OWN0: begin
        if (request[0])      state_nxt = OWN0;
        else if (request[1]) state_nxt = OWN1;
        else                 state_nxt = IDLE;
      end
      OWN1: begin
        if (request[1])      state_nxt = OWN1;
        else if (request[0]) state_nxt = OWN0;
        else                 state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= GRANT_RST;
`ifdef ARB_ROUND_ROBIN_EN
      last_ptr <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      grant <= {state_nxt == OWN1, state_nxt == OWN0};
`ifdef ARB_ROUND_ROBIN_EN
      if (state_nxt != state) begin
        if (state_nxt == OWN0)      last_ptr <= 1'b0;
        else if (state_nxt == OWN1) last_ptr <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rtl.sv
// Self-checking bench for the arbiter: directed scenarios then random traffic,
// compared against an owner/last-granted model; honours ARB_ROUND_ROBIN_EN.
module tb_rtl;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RoundRobin = 1'b1;
`else
  localparam bit RoundRobin = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] request;
  logic [1:0] grant;

  int n_total = 0;
  int n_bad   = 0;

  // Model: current owner (-1 = free) and most recently granted requester.
  int owner = -1;
  int last  = 1;

  rtl #(.NUM_REQ(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .request(request),
    .grant  (grant)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [1:0] r, input logic rs);
    int nxt;
    if (rs) begin
      owner = -1;
      last  = 1;
    end else begin
      if (owner >= 0) begin
        if (r[owner])          nxt = owner;
        else if (r[1 - owner]) nxt = 1 - owner;
        else                   nxt = -1;
      end else begin
        if (r == 2'b11) nxt = RoundRobin ? 1 - last : 0;
        else if (r[0])  nxt = 0;
        else if (r[1])  nxt = 1;
        else            nxt = -1;
      end
      if (nxt >= 0 && nxt != owner) last = nxt;
      owner = nxt;
    end
  endtask

  // Drive inputs, take one edge, check grant 1 time unit after it.
  task automatic cycle(input string tag, input logic [1:0] r, input logic rs);
    logic [1:0] exp_grant;
    request = r;
    rst     = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
    exp_grant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    check_eq(tag, {30'b0, grant}, {30'b0, exp_grant});
    check_eq("onehot0", {31'b0, ($countones(grant) <= 1)}, 32'd1);
  endtask

  initial begin
    request = 2'b00;
    rst     = 1'b1;
    cycle("reset_a", 2'b00, 1'b1);
    cycle("reset_b", 2'b11, 1'b1);

    cycle("first_req", 2'b01, 1'b0);
    cycle("handover_0to1", 2'b10, 1'b0);
    cycle("own1_hold_both", 2'b11, 1'b0);
    cycle("own1_release_to0", 2'b01, 1'b0);
    cycle("reset_mid_own", 2'b01, 1'b1);
    cycle("after_reset", 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) cycle("idle_after_release", 2'b00, 1'b0);

    cycle("tie_first", 2'b11, 1'b0);
    cycle("tie_release", 2'b00, 1'b0);
    cycle("tie_second", 2'b11, 1'b0);
    cycle("tie_release2", 2'b00, 1'b0);
    cycle("single_1", 2'b10, 1'b0);
    cycle("tie_release3", 2'b00, 1'b0);
    cycle("tie_third", 2'b11, 1'b0);
    cycle("tie_release4", 2'b00, 1'b0);

    for (int i = 0; i < 400; i++) begin
      cycle("random", 2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
